// File: rtl/bk_page_mmu_pkg.sv
// Shared types for the BK paged MMU.
//   state_t      : sequencer states, also exported on the debug state port
//   page_entry_t : decoded page register {valid, ro, page}. The page field is
//                  sized for the widest supported page number; narrower
//                  configurations zero-extend into it.
package bk_mmu_pkg;

   localparam int PAGE_W_MAX = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WAIT  = 3'd1,
      REQ   = 3'd2,
      ACK   = 3'd3,
      FAULT = 3'd4
   } state_t;

   typedef struct packed {
      logic                  valid;
      logic                  ro;
      logic [PAGE_W_MAX-1:0] page;
   } page_entry_t;

endpackage

// File: rtl/bk_page_mmu_if.sv
// CPU-side bus of the BK paged MMU.
// Handshake: the CPU presents bus_addr/bus_we/bus_wtbt/bus_din with bus_sync
// and bus_stb high and holds them until it sees bus_ack; the MMU keeps bus_ack
// (and bus_dout on reads) high until the CPU drops bus_stb. A dropped bus_stb
// before bus_ack abandons the cycle from the CPU's point of view.
//   master : CPU side (drives address, data, strobes)
//   slave  : MMU side (drives bus_dout, bus_ack)
interface bk_page_mmu_if;
   logic [15:0] bus_addr;
   logic [15:0] bus_din;
   logic [15:0] bus_dout;
   logic        bus_sync;
   logic        bus_stb;
   logic        bus_we;
   logic [1:0]  bus_wtbt;
   logic        bus_ack;

   modport master (
      output bus_addr, bus_din, bus_sync, bus_stb, bus_we, bus_wtbt,
      input  bus_dout, bus_ack
   );

   modport slave (
      input  bus_addr, bus_din, bus_sync, bus_stb, bus_we, bus_wtbt,
      output bus_dout, bus_ack
   );
endinterface

// File: rtl/bk_page_regs.sv
// Page register file: WINDOWS entries of {valid, ro, page[PAGE_BITS-1:0]}.
// Reset value of entry i is {1, 0, i} (identity map, all writable).
// Ports:
//   clk_bus, reset_n : clock, asynchronous active-low reset
//   we, widx, wdata  : single write port, effective after the clock edge
//   ridx_a / rdata_a : combinational read port (address translation)
//   ridx_b / rdata_b : combinational read port (configuration readback)
module bk_page_regs #(
   parameter int WINDOWS   = 4,
   parameter int PAGE_BITS = 11,
   localparam int WB = $clog2(WINDOWS),
   localparam int EW = PAGE_BITS + 2
) (
   input  logic          clk_bus,
   input  logic          reset_n,
   input  logic          we,
   input  logic [WB-1:0] widx,
   input  logic [EW-1:0] wdata,
   input  logic [WB-1:0] ridx_a,
   output logic [EW-1:0] rdata_a,
   input  logic [WB-1:0] ridx_b,
   output logic [EW-1:0] rdata_b
);

   logic [EW-1:0] regs_q [WINDOWS];
   logic [EW-1:0] regs_d [WINDOWS];

   always_comb begin
      regs_d = regs_q;
      if (we) regs_d[widx] = wdata;
   end

   always_ff @(posedge clk_bus or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < WINDOWS; i++) regs_q[i] <= {1'b1, 1'b0, PAGE_BITS'(i)};
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rdata_a = regs_q[ridx_a];
   assign rdata_b = regs_q[ridx_b];

endmodule

// File: rtl/bk_page_mmu.sv
// Paged MMU and bus-to-SDRAM sequencer for the BK CPU bus.
// The 64KB CPU space is split into WINDOWS windows, each mapped through a page
// register onto a physical page. Accesses to legacy pages take LEGACY_WAIT
// contention cycles before the SDRAM request. Writes to read-only pages and
// accesses through invalid entries raise a one-cycle fault and are never acked.
// Ports:
//   clk_bus, reset_n          : clock, asynchronous active-low reset
//   bus                       : CPU bus (slave modport)
//   fault, screen_write       : one-cycle status pulses
//   cfg_we/cfg_idx/cfg_din    : page register write, cfg_dout = entry at cfg_idx
//   ram_req/ram_ready         : SDRAM request held until ready
//   ram_addr/we/wtbt/din/dout : SDRAM word address, command and data
//   dbg_state                 : current sequencer state
module bk_page_mmu
   import bk_mmu_pkg::*;
#(
   parameter int          WINDOWS      = 4,
   parameter int          PAGE_BITS    = 11,
   parameter int          LEGACY_PAGES = 8,
   parameter int          LEGACY_WAIT  = 3,
   parameter logic [15:0] IO_BASE      = 16'o177000,
   parameter int          SCREEN_P0    = 5,
   parameter int          SCREEN_P1    = 6,
   localparam int WB      = $clog2(WINDOWS),
   localparam int PHYS_AW = PAGE_BITS + 16 - WB,
   localparam int EW      = PAGE_BITS + 2,
   localparam int CW      = (LEGACY_WAIT > 3) ? $clog2(LEGACY_WAIT) : 2
) (
   input  logic               clk_bus,
   input  logic               reset_n,
   bk_page_mmu_if.slave       bus,
   output logic               fault,
   output logic [1:0]         screen_write,
   input  logic               cfg_we,
   input  logic [WB-1:0]      cfg_idx,
   input  logic [EW-1:0]      cfg_din,
   output logic [EW-1:0]      cfg_dout,
   output logic               ram_req,
   input  logic               ram_ready,
   output logic [PHYS_AW-2:0] ram_addr,
   output logic               ram_we,
   output logic [1:0]         ram_wtbt,
   output logic [15:0]        ram_din,
   input  logic [15:0]        ram_dout,
   output state_t             dbg_state
);

   logic [EW-1:0] t_raw;
   page_entry_t   t_ent;
   logic          hit, t_legacy, addr_lsb_unused;

   bk_page_regs #(.WINDOWS(WINDOWS), .PAGE_BITS(PAGE_BITS)) u_regs (
      .clk_bus (clk_bus),
      .reset_n (reset_n),
      .we      (cfg_we),
      .widx    (cfg_idx),
      .wdata   (cfg_din),
      .ridx_a  (bus.bus_addr[15:16-WB]),
      .rdata_a (t_raw),
      .ridx_b  (cfg_idx),
      .rdata_b (cfg_dout)
   );

   // Byte lane selection is carried by bus_wtbt; the SDRAM is word addressed.
   assign addr_lsb_unused = bus.bus_addr[0];

   always_comb begin
      t_ent       = '0;
      t_ent.valid = t_raw[PAGE_BITS+1];
      t_ent.ro    = t_raw[PAGE_BITS];
      t_ent.page  = PAGE_W_MAX'(t_raw[PAGE_BITS-1:0]);
   end

   assign hit      = bus.bus_sync && bus.bus_stb && (bus.bus_addr < IO_BASE);
   assign t_legacy = (t_ent.page < PAGE_W_MAX'(LEGACY_PAGES)) && (LEGACY_WAIT > 0);

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                abort_q, abort_d;
   logic [1:0]          scr_hit_q, scr_hit_d;
   logic                ack_q, ack_d;
   logic [15:0]         dout_q, dout_d;
   logic                fault_q, fault_d;
   logic [1:0]          scr_q, scr_d;
   logic                req_q, req_d;
   logic [PHYS_AW-2:0]  addr_q, addr_d;
   logic                we_q, we_d;
   logic [1:0]          wtbt_q, wtbt_d;
   logic [15:0]         din_q, din_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      abort_d   = abort_q;
      scr_hit_d = scr_hit_q;
      ack_d     = ack_q;
      dout_d    = dout_q;
      fault_d   = 1'b0;
      scr_d     = 2'b00;
      req_d     = req_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wtbt_d    = wtbt_q;
      din_d     = din_q;
      case (state_q)
         IDLE: begin
            ack_d  = 1'b0;
            dout_d = '0;
            if (hit) begin
               if (!t_ent.valid || (bus.bus_we && t_ent.ro)) begin
                  state_d = FAULT;
                  fault_d = 1'b1;
               end else begin
                  // Everything the SDRAM op needs is latched here, so later
                  // cfg writes cannot disturb an access already in flight.
                  addr_d    = {t_ent.page[PAGE_BITS-1:0], bus.bus_addr[15-WB:1]};
                  we_d      = bus.bus_we;
                  wtbt_d    = bus.bus_we ? bus.bus_wtbt : 2'b11;
                  din_d     = bus.bus_din;
                  abort_d   = 1'b0;
                  scr_hit_d = {t_ent.page == PAGE_W_MAX'(SCREEN_P1),
                               t_ent.page == PAGE_W_MAX'(SCREEN_P0)};
                  if (t_legacy) begin
                     state_d = WAIT;
                     cnt_d   = CW'(LEGACY_WAIT - 1);
                  end else begin
                     state_d = REQ;
                     req_d   = 1'b1;
                  end
               end
            end
         end
         WAIT: begin
            if (!bus.bus_stb) abort_d = 1'b1;
            if (cnt_q == '0) begin
               state_d = REQ;
               req_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         REQ: begin
            if (!bus.bus_stb) abort_d = 1'b1;
            if (ram_ready) begin
               // The SDRAM op always completes; an abort only hides the reply.
               req_d = 1'b0;
               if (we_q) scr_d = scr_hit_q;
               if (abort_q || !bus.bus_stb) begin
                  state_d = IDLE;
               end else begin
                  state_d = ACK;
                  ack_d   = 1'b1;
                  dout_d  = we_q ? 16'h0000 : ram_dout;
               end
            end
         end
         ACK: begin
            if (!bus.bus_stb) begin
               state_d = IDLE;
               ack_d   = 1'b0;
               dout_d  = '0;
            end
         end
         FAULT: begin
            if (!bus.bus_stb) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_bus or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         abort_q   <= 1'b0;
         scr_hit_q <= 2'b00;
         ack_q     <= 1'b0;
         dout_q    <= '0;
         fault_q   <= 1'b0;
         scr_q     <= 2'b00;
         req_q     <= 1'b0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wtbt_q    <= 2'b00;
         din_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         abort_q   <= abort_d;
         scr_hit_q <= scr_hit_d;
         ack_q     <= ack_d;
         dout_q    <= dout_d;
         fault_q   <= fault_d;
         scr_q     <= scr_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wtbt_q    <= wtbt_d;
         din_q     <= din_d;
      end
   end

   assign bus.bus_ack   = ack_q;
   assign bus.bus_dout  = dout_q;
   assign fault         = fault_q;
   assign screen_write  = scr_q;
   assign ram_req       = req_q;
   assign ram_addr      = addr_q;
   assign ram_we        = we_q;
   assign ram_wtbt      = wtbt_q;
   assign ram_din       = din_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_bk_page_mmu.sv
// Directed bench for bk_page_mmu at default parameters.
module tb_bk_page_mmu;
   import bk_mmu_pkg::*;

   logic        clk_bus;
   logic        reset_n;
   logic        fault;
   logic [1:0]  screen_write;
   logic        cfg_we;
   logic [1:0]  cfg_idx;
   logic [12:0] cfg_din;
   logic [12:0] cfg_dout;
   logic        ram_req;
   logic        ram_ready;
   logic [23:0] ram_addr;
   logic        ram_we;
   logic [1:0]  ram_wtbt;
   logic [15:0] ram_din;
   logic [15:0] ram_dout;
   state_t      dbg_state;

   bk_page_mmu_if bus_if ();

   bk_page_mmu dut (
      .clk_bus      (clk_bus),
      .reset_n      (reset_n),
      .bus          (bus_if),
      .fault        (fault),
      .screen_write (screen_write),
      .cfg_we       (cfg_we),
      .cfg_idx      (cfg_idx),
      .cfg_din      (cfg_din),
      .cfg_dout     (cfg_dout),
      .ram_req      (ram_req),
      .ram_ready    (ram_ready),
      .ram_addr     (ram_addr),
      .ram_we       (ram_we),
      .ram_wtbt     (ram_wtbt),
      .ram_din      (ram_din),
      .ram_dout     (ram_dout),
      .dbg_state    (dbg_state)
   );

   // clock / reset
   initial clk_bus = 1'b0;
   always #5 clk_bus = ~clk_bus;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        cfg_en;
      logic [1:0]  cfg_i;
      logic [12:0] cfg_v;
      logic [15:0] addr;
      logic        we;
      logic [1:0]  wtbt;
      logic [15:0] din;
      logic [15:0] rdata;
      logic        e_fault;
      logic        e_ack;
      int          e_req_cyc;
      logic [23:0] e_addr;
      logic [1:0]  e_wtbt;
      logic [15:0] e_dout;
      logic [1:0]  e_scr;
   } vec_t;

   // driver tasks
   task automatic cfg_write(input logic [1:0] idx, input logic [12:0] val);
      cfg_we  = 1'b1;
      cfg_idx = idx;
      cfg_din = val;
      @(negedge clk_bus);
      cfg_we = 1'b0;
      check("cfg_dout", 32'(cfg_dout), 32'(val));
   endtask

   task automatic apply_vec(input vec_t v, input int n);
      int          fault_cyc, scr_cyc, req_cnt, req_cyc, ack_cyc;
      logic [1:0]  scr_seen;
      logic [23:0] got_addr;
      logic [1:0]  got_wtbt;
      logic        got_we;
      logic [15:0] got_din, got_dout;
      string       tag;
      fault_cyc = 0; scr_cyc = 0; req_cnt = 0; req_cyc = 0; ack_cyc = 0;
      scr_seen = 2'b00; got_addr = '0; got_wtbt = '0; got_we = 1'b0;
      got_din = '0; got_dout = '0;
      tag = $sformatf("v%0d", n);
      if (v.cfg_en) cfg_write(v.cfg_i, v.cfg_v);
      bus_if.bus_addr = v.addr;
      bus_if.bus_we   = v.we;
      bus_if.bus_wtbt = v.wtbt;
      bus_if.bus_din  = v.din;
      bus_if.bus_sync = 1'b1;
      bus_if.bus_stb  = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk_bus);
         if (fault) fault_cyc++;
         if (screen_write != 2'b00) begin
            scr_cyc++;
            scr_seen |= screen_write;
         end
         if (ram_ready) begin
            ram_ready = 1'b0;
         end else if (ram_req) begin
            req_cnt++;
            if (req_cnt == 1) begin
               req_cyc  = c;
               got_addr = ram_addr;
               got_wtbt = ram_wtbt;
               got_we   = ram_we;
               got_din  = ram_din;
            end
            ram_ready = 1'b1;
            ram_dout  = v.rdata;
         end
         if (bus_if.bus_ack) begin
            ack_cyc  = c;
            got_dout = bus_if.bus_dout;
            break;
         end
      end
      check({tag, "_fault_cycles"}, 32'(fault_cyc), v.e_fault ? 32'd1 : 32'd0);
      check({tag, "_ack"}, 32'(ack_cyc != 0), 32'(v.e_ack));
      check({tag, "_req_count"}, 32'(req_cnt), v.e_ack ? 32'd1 : 32'd0);
      if (v.e_ack) begin
         check({tag, "_req_latency"}, 32'(req_cyc), 32'(v.e_req_cyc));
         check({tag, "_ack_latency"}, 32'(ack_cyc), 32'(v.e_req_cyc + 1));
         check({tag, "_ram_addr"}, 32'(got_addr), 32'(v.e_addr));
         check({tag, "_ram_wtbt"}, 32'(got_wtbt), 32'(v.e_wtbt));
         check({tag, "_ram_we"}, 32'(got_we), 32'(v.we));
         if (v.we) check({tag, "_ram_din"}, 32'(got_din), 32'(v.din));
         check({tag, "_bus_dout"}, 32'(got_dout), 32'(v.e_dout));
         check({tag, "_screen"}, 32'(scr_seen), 32'(v.e_scr));
         check({tag, "_screen_cycles"}, 32'(scr_cyc), (v.e_scr != 2'b00) ? 32'd1 : 32'd0);
      end
      bus_if.bus_stb  = 1'b0;
      bus_if.bus_sync = 1'b0;
      ram_ready = 1'b0;
      @(negedge clk_bus);
      check({tag, "_ack_release"}, 32'(bus_if.bus_ack), 32'd0);
      check({tag, "_dout_release"}, 32'(bus_if.bus_dout), 32'd0);
      check({tag, "_state_idle"}, 32'(dbg_state), 32'(IDLE));
      check({tag, "_pulses_clear"}, 32'({fault, screen_write}), 32'd0);
   endtask

   vec_t vecs[12];

   initial begin
      int          req_cnt;
      logic        ack_seen;
      logic [23:0] got_addr;
      vec_t        post;

      reset_n = 1'b0;
      cfg_we = 1'b0; cfg_idx = '0; cfg_din = '0;
      ram_ready = 1'b0; ram_dout = '0;
      bus_if.bus_addr = '0; bus_if.bus_din = '0; bus_if.bus_sync = 1'b0;
      bus_if.bus_stb = 1'b0; bus_if.bus_we = 1'b0; bus_if.bus_wtbt = 2'b00;

      //           cfg   idx   val                   addr      we    wtbt   din       rdata     flt   ack   lat  ram_addr    wtbt   dout      scr
      vecs[0]  = '{1'b0, 2'd0, 13'd0,                16'h4000, 1'b0, 2'b00, 16'h0000, 16'h1234, 1'b0, 1'b1, 4,   24'h002000, 2'b11, 16'h1234, 2'b00};
      vecs[1]  = '{1'b1, 2'd1, {2'b10, 11'd6},       16'h4002, 1'b1, 2'b01, 16'hBEEF, 16'h0000, 1'b0, 1'b1, 4,   24'h00C001, 2'b01, 16'h0000, 2'b10};
      vecs[2]  = '{1'b1, 2'd2, {2'b11, 11'd56},      16'h8000, 1'b1, 2'b11, 16'h5555, 16'h0000, 1'b1, 1'b0, 0,   24'h000000, 2'b00, 16'h0000, 2'b00};
      vecs[3]  = '{1'b0, 2'd0, 13'd0,                16'h8000, 1'b0, 2'b00, 16'h0000, 16'h5A5A, 1'b0, 1'b1, 1,   24'h070000, 2'b11, 16'h5A5A, 2'b00};
      vecs[4]  = '{1'b1, 2'd3, {2'b00, 11'd3},       16'hC000, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 0,   24'h000000, 2'b00, 16'h0000, 2'b00};
      vecs[5]  = '{1'b0, 2'd0, 13'd0,                16'hFFC0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 0,   24'h000000, 2'b00, 16'h0000, 2'b00};
      vecs[6]  = '{1'b0, 2'd0, 13'd0,                16'h0000, 1'b0, 2'b00, 16'h0000, 16'hAAAA, 1'b0, 1'b1, 4,   24'h000000, 2'b11, 16'hAAAA, 2'b00};
      vecs[7]  = '{1'b0, 2'd0, 13'd0,                16'h1FFE, 1'b1, 2'b10, 16'h1357, 16'h0000, 1'b0, 1'b1, 4,   24'h000FFF, 2'b10, 16'h0000, 2'b00};
      vecs[8]  = '{1'b1, 2'd0, {2'b10, 11'd5},       16'h0010, 1'b1, 2'b11, 16'h2468, 16'h0000, 1'b0, 1'b1, 4,   24'h00A008, 2'b11, 16'h0000, 2'b01};
      vecs[9]  = '{1'b1, 2'd2, {2'b10, 11'h7FF},     16'hBFFE, 1'b0, 2'b00, 16'h0000, 16'h0F0F, 1'b0, 1'b1, 1,   24'hFFFFFF, 2'b11, 16'h0F0F, 2'b00};
      vecs[10] = '{1'b1, 2'd3, {2'b10, 11'd3},       16'hFDFE, 1'b0, 2'b00, 16'h0000, 16'h7777, 1'b0, 1'b1, 4,   24'h007EFF, 2'b11, 16'h7777, 2'b00};
      vecs[11] = '{1'b0, 2'd0, 13'd0,                16'hFE00, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 0,   24'h000000, 2'b00, 16'h0000, 2'b00};

      // reset state
      repeat (2) @(negedge clk_bus);
      check("rst_ram_req", 32'(ram_req), 32'd0);
      check("rst_ack", 32'(bus_if.bus_ack), 32'd0);
      check("rst_outputs", 32'({fault, screen_write, ram_we, ram_wtbt}), 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cfg_idx = 2'(i);
         #1;
         check($sformatf("rst_page%0d", i), 32'(cfg_dout), 32'({2'b10, 11'(i)}));
      end
      @(negedge clk_bus);

      for (int i = 0; i < 12; i++) apply_vec(vecs[i], i);

      // abort during WAIT, with a cfg write to the same window in flight
      bus_if.bus_addr = 16'h4000;
      bus_if.bus_we = 1'b0;
      bus_if.bus_sync = 1'b1;
      bus_if.bus_stb = 1'b1;
      @(negedge clk_bus);
      check("abort_in_wait", 32'(dbg_state), 32'(WAIT));
      bus_if.bus_stb = 1'b0;
      bus_if.bus_sync = 1'b0;
      cfg_we = 1'b1; cfg_idx = 2'd1; cfg_din = {2'b10, 11'd9};
      req_cnt = 0; ack_seen = 1'b0; got_addr = '0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk_bus);
         cfg_we = 1'b0;
         if (ram_ready) begin
            ram_ready = 1'b0;
         end else if (ram_req) begin
            req_cnt++;
            got_addr = ram_addr;
            ram_ready = 1'b1;
            ram_dout = 16'hDEAD;
         end
         if (bus_if.bus_ack) ack_seen = 1'b1;
      end
      check("abort_req_count", 32'(req_cnt), 32'd1);
      check("abort_ram_addr", 32'(got_addr), 32'h00C000);
      check("abort_no_ack", 32'(ack_seen), 32'd0);
      check("abort_dout", 32'(bus_if.bus_dout), 32'd0);
      check("abort_state", 32'(dbg_state), 32'(IDLE));

      // reset while a request is outstanding
      bus_if.bus_addr = 16'h8000;
      bus_if.bus_sync = 1'b1;
      bus_if.bus_stb = 1'b1;
      @(negedge clk_bus);
      check("rst_mid_req_up", 32'(ram_req), 32'd1);
      reset_n = 1'b0;
      #1;
      check("rst_mid_req_drop", 32'(ram_req), 32'd0);
      check("rst_mid_ack", 32'(bus_if.bus_ack), 32'd0);
      check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
      bus_if.bus_stb = 1'b0;
      bus_if.bus_sync = 1'b0;
      @(negedge clk_bus);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cfg_idx = 2'(i);
         #1;
         check($sformatf("rst2_page%0d", i), 32'(cfg_dout), 32'({2'b10, 11'(i)}));
      end
      @(negedge clk_bus);
      post = '{1'b0, 2'd0, 13'd0, 16'h4000, 1'b0, 2'b00, 16'h0000, 16'hC0DE, 1'b0, 1'b1, 4, 24'h002000, 2'b11, 16'hC0DE, 2'b00};
      apply_vec(post, 99);

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
